// File: rtl/vend_pkg.sv
// Shared types and default parameters for the vending change controller.
package vend_pkg;

    localparam int W_DEF           = 8;
    localparam int CHANGE_UNIT_DEF = 5;
    localparam int TIMEOUT_CYC_DEF = 1000;

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        VEND,
        CHANGE,
        REFUND
    } vend_state_t;

endpackage

// File: rtl/vend_change_ctrl_if.sv
// Front-end / actuator signal bundle of the vending change controller.
interface vend_change_ctrl_if #(
    parameter int W = vend_pkg::W_DEF
);
    logic         coin_in;
    logic [W-1:0] coin_value;
    logic [W-1:0] price;
    logic         cancel;
    logic         dispense_ack;
    logic         change_ack;
    logic         dispense;
    logic         change_req;
    logic [W-1:0] credit;
    logic [W-1:0] residue;
    logic         busy;

    // Front end / actuators side.
    modport master (
        output coin_in, coin_value, price, cancel, dispense_ack, change_ack,
        input  dispense, change_req, credit, residue, busy
    );

    // Controller side.
    modport slave (
        input  coin_in, coin_value, price, cancel, dispense_ack, change_ack,
        output dispense, change_req, credit, residue, busy
    );
endinterface

// File: rtl/coin_edge_sync.sv
// Brings the asynchronous coin-present level into the clk domain and emits
// a single-cycle pulse per rising edge.
module coin_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic coin_in,
    output logic coin_evt
);
    logic sync1_q;
    logic sync2_q;
    logic sync2_d_q;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbour; blocking here would
    // collapse the synchronizer chain into a single flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            sync2_d_q <= 1'b0;
            coin_evt  <= 1'b0;
        end else begin
            sync1_q   <= coin_in;
            sync2_q   <= sync1_q;
            sync2_d_q <= sync2_q;
            coin_evt  <= sync2_q & ~sync2_d_q;
        end
    end

endmodule

// File: rtl/vend_change_ctrl.sv
// Vending sequencer: collects coin credit, requests dispense, then pays out
// change (or a full refund) one CHANGE_UNIT at a time.
module vend_change_ctrl
    import vend_pkg::*;
#(
    parameter int W           = W_DEF,
    parameter int CHANGE_UNIT = CHANGE_UNIT_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input logic              clk,
    input logic              rst_n,
    vend_change_ctrl_if.slave bus
);
    localparam int            CW       = $clog2(TIMEOUT_CYC);
    localparam logic [W-1:0]  UNIT     = W'(CHANGE_UNIT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 2);

    vend_state_t   state_q,      state_n;
    logic [W-1:0]  credit_q,     credit_n;
    logic [W-1:0]  price_q,      price_n;
    logic [W-1:0]  residue_q,    residue_n;
    logic [CW-1:0] cnt_q,        cnt_n;
    logic          dispense_q,   dispense_n;
    logic          change_req_q, change_req_n;
    logic          busy_q;
    logic          coin_evt;

    logic [W:0]    credit_sum;
    logic [W-1:0]  credit_add;

    coin_edge_sync u_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .coin_in  (bus.coin_in),
        .coin_evt (coin_evt)
    );

    assign credit_sum = {1'b0, credit_q} + {1'b0, bus.coin_value};
    assign credit_add = credit_sum[W] ? '1 : credit_sum[W-1:0];

    // NOTE: every signal written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        state_n      = state_q;
        credit_n     = credit_q;
        price_n      = price_q;
        residue_n    = residue_q;
        cnt_n        = '0;
        dispense_n   = dispense_q;
        change_req_n = change_req_q;

        unique case (state_q)
            IDLE: begin
                if (coin_evt) begin
                    price_n  = bus.price;
                    credit_n = credit_add;
                    state_n  = COLLECT;
                end
            end

            COLLECT: begin
                credit_n = coin_evt ? credit_add : credit_q;
                cnt_n    = coin_evt ? '0 : cnt_q + 1'b1;
                // Decisions use the credit including this cycle's coin.
                if (credit_n >= price_q) begin
                    state_n    = VEND;
                    dispense_n = 1'b1;
                end else if (bus.cancel || (!coin_evt && cnt_q == CNT_LAST)) begin
                    state_n      = REFUND;
                    change_req_n = (credit_n >= UNIT);
                end
            end

            VEND: begin
                if (dispense_q && bus.dispense_ack) begin
                    credit_n     = credit_q - price_q;
                    dispense_n   = 1'b0;
                    state_n      = CHANGE;
                    change_req_n = (credit_n >= UNIT);
                end
            end

            CHANGE, REFUND: begin
                if (change_req_q) begin
                    // Dropping the request after each ack gives the hopper a gap.
                    if (bus.change_ack) begin
                        credit_n     = credit_q - UNIT;
                        change_req_n = 1'b0;
                    end
                end else if (credit_q >= UNIT) begin
                    change_req_n = 1'b1;
                end else begin
                    residue_n = credit_q;
                    credit_n  = '0;
                    state_n   = IDLE;
                end
            end

            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            credit_q     <= '0;
            price_q      <= '0;
            residue_q    <= '0;
            cnt_q        <= '0;
            dispense_q   <= 1'b0;
            change_req_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_n;
            credit_q     <= credit_n;
            price_q      <= price_n;
            residue_q    <= residue_n;
            cnt_q        <= cnt_n;
            dispense_q   <= dispense_n;
            change_req_q <= change_req_n;
            busy_q       <= (state_n != IDLE);
        end
    end

    assign bus.dispense   = dispense_q;
    assign bus.change_req = change_req_q;
    assign bus.credit     = credit_q;
    assign bus.residue    = residue_q;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_vend_change_ctrl.sv
// Scenario bench for vend_change_ctrl: payout expectations are queued when
// the deciding stimulus is driven and checked when the payout completes.
module tb_vend_change_ctrl;
    localparam int W = 8;
    localparam int U = 5;
    localparam int T = 24;

    logic clk;
    logic rst_n;

    vend_change_ctrl_if #(.W(W)) bus ();

    vend_change_ctrl #(
        .W           (W),
        .CHANGE_UNIT (U),
        .TIMEOUT_CYC (T)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        string        tag;
        int           units;
        logic [W-1:0] residue;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   mdl_credit = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no end of test, want finish");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic coin_start(input int v);
        bus.coin_value = W'(v);
        bus.coin_in    = 1'b1;
        mdl_credit     = (mdl_credit + v > 255) ? 255 : mdl_credit + v;
    endtask

    task automatic drive_coin(input int v);
        coin_start(v);
        tick(5);
        bus.coin_in = 1'b0;
        tick(3);
    endtask

    task automatic expect_payout(input string tag, input int rem);
        exp_t e;
        e.tag     = tag;
        e.units   = rem / U;
        e.residue = W'(rem % U);
        exp_q.push_back(e);
    endtask

    task automatic do_vend(input string tag, input logic [W-1:0] exp_credit);
        bit seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (bus.dispense) seen = 1'b1;
        end
        n_cmp++;
        if (seen !== 1'b1) begin
            n_bad++;
            $display("FAIL %s_dispense: got no dispense in 50 cycles, want dispense=1", tag);
        end
        n_cmp++;
        if (bus.credit !== exp_credit) begin
            n_bad++;
            $display("FAIL %s_credit: got %0d, want %0d", tag, bus.credit, exp_credit);
        end
        tick(2);
        n_cmp++;
        if (bus.dispense !== 1'b1) begin
            n_bad++;
            $display("FAIL %s_dispense_hold: got %b, want 1", tag, bus.dispense);
        end
        bus.dispense_ack = 1'b1;
        @(negedge clk);
        bus.dispense_ack = 1'b0;
        n_cmp++;
        if (bus.dispense !== 1'b0) begin
            n_bad++;
            $display("FAIL %s_dispense_drop: got %b, want 0", tag, bus.dispense);
        end
    endtask

    task automatic run_payout();
        exp_t e;
        int   units = 0;
        bit   done  = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            if (!bus.busy) begin
                done = 1'b1;
            end else if (bus.change_req) begin
                units++;
                bus.change_ack = 1'b1;
                @(negedge clk);
                bus.change_ack = 1'b0;
                n_cmp++;
                if (bus.change_req !== 1'b0) begin
                    n_bad++;
                    $display("FAIL req_gap: got change_req=%b after ack, want 0", bus.change_req);
                end
            end
        end
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL payout_timeout: got busy=1 after 300 cycles, want 0");
        end
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard: got payout with empty queue, want an expectation");
        end else begin
            e = exp_q.pop_front();
            n_cmp++;
            if (units !== e.units) begin
                n_bad++;
                $display("FAIL %s_units: got %0d, want %0d", e.tag, units, e.units);
            end
            n_cmp++;
            if (bus.residue !== e.residue) begin
                n_bad++;
                $display("FAIL %s_residue: got %0d, want %0d", e.tag, bus.residue, e.residue);
            end
            n_cmp++;
            if (bus.credit !== '0) begin
                n_bad++;
                $display("FAIL %s_credit_end: got %0d, want 0", e.tag, bus.credit);
            end
        end
        mdl_credit = 0;
    endtask

    task automatic test_reset();
        rst_n            = 1'b0;
        bus.coin_in      = 1'b0;
        bus.coin_value   = '0;
        bus.price        = '0;
        bus.cancel       = 1'b0;
        bus.dispense_ack = 1'b0;
        bus.change_ack   = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(2);
        n_cmp++;
        if ({bus.dispense, bus.change_req, bus.busy} !== 3'b000) begin
            n_bad++;
            $display("FAIL reset_flags: got %b, want 000", {bus.dispense, bus.change_req, bus.busy});
        end
        n_cmp++;
        if (bus.credit !== '0 || bus.residue !== '0) begin
            n_bad++;
            $display("FAIL reset_values: got credit=%0d residue=%0d, want 0/0", bus.credit, bus.residue);
        end
    endtask

    task automatic test_exact_price();
        bus.price = 8'd15;
        drive_coin(10);
        n_cmp++;
        if (bus.credit !== 8'd10 || bus.busy !== 1'b1 || bus.dispense !== 1'b0) begin
            n_bad++;
            $display("FAIL exact_collect: got credit=%0d busy=%b dispense=%b, want 10/1/0",
                     bus.credit, bus.busy, bus.dispense);
        end
        drive_coin(5);
        expect_payout("exact", mdl_credit - 15);
        do_vend("exact", 8'd15);
        run_payout();
    endtask

    task automatic test_change();
        bus.price = 8'd15;
        drive_coin(10);
        bus.price = 8'd200;  // must not affect the latched price
        drive_coin(10);
        expect_payout("change", mdl_credit - 15);
        do_vend("change", 8'd20);
        n_cmp++;
        if (bus.credit !== 8'd5) begin
            n_bad++;
            $display("FAIL change_rem: got %0d, want 5", bus.credit);
        end
        run_payout();
    endtask

    task automatic test_cancel_refund();
        bus.price = 8'd20;
        drive_coin(13);
        expect_payout("cancel", mdl_credit);
        bus.cancel = 1'b1;
        run_payout();
        bus.cancel = 1'b0;
        n_cmp++;
        if (bus.busy !== 1'b0) begin
            n_bad++;
            $display("FAIL cancel_busy: got %b, want 0", bus.busy);
        end
    endtask

    task automatic test_coin_with_cancel();
        bus.price = 8'd100;
        drive_coin(20);
        coin_start(7);
        tick(3);
        bus.cancel = 1'b1;  // lands in the same cycle as the coin event
        expect_payout("coin_cancel", mdl_credit);
        run_payout();
        bus.cancel  = 1'b0;
        bus.coin_in = 1'b0;
        tick(3);
    endtask

    task automatic test_spurious_acks();
        bus.dispense_ack = 1'b1;
        bus.change_ack   = 1'b1;
        bus.cancel       = 1'b1;
        @(negedge clk);
        bus.dispense_ack = 1'b0;
        bus.change_ack   = 1'b0;
        bus.cancel       = 1'b0;
        tick(2);
        n_cmp++;
        if ({bus.busy, bus.dispense, bus.change_req} !== 3'b000) begin
            n_bad++;
            $display("FAIL spurious_flags: got %b, want 000", {bus.busy, bus.dispense, bus.change_req});
        end
        n_cmp++;
        if (bus.credit !== '0 || bus.residue !== 8'd2) begin
            n_bad++;
            $display("FAIL spurious_values: got credit=%0d residue=%0d, want 0/2", bus.credit, bus.residue);
        end
    endtask

    task automatic test_timeout();
        int  k    = 0;
        bit  seen = 1'b0;
        bus.price = 8'd50;
        coin_start(10);
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (bus.busy) seen = 1'b1;
        end
        bus.coin_in = 1'b0;
        // busy rises one cycle after the coin event, so REFUND follows T-1 cycles later
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            k++;
            if (bus.change_req) seen = 1'b1;
        end
        n_cmp++;
        if (k !== T - 1 || seen !== 1'b1) begin
            n_bad++;
            $display("FAIL timeout_latency: got %0d cycles (seen=%b), want %0d", k, seen, T - 1);
        end
        expect_payout("timeout", mdl_credit);
        run_payout();
    endtask

    task automatic test_saturation();
        bus.price = 8'd255;
        drive_coin(250);
        n_cmp++;
        if (bus.credit !== 8'd250) begin
            n_bad++;
            $display("FAIL sat_first: got %0d, want 250", bus.credit);
        end
        drive_coin(250);
        expect_payout("sat", mdl_credit - 255);
        do_vend("sat", 8'd255);
        run_payout();
    endtask

    task automatic test_zero_price();
        bus.price = 8'd0;
        drive_coin(5);
        expect_payout("zero_price", mdl_credit);
        do_vend("zero_price", 8'd5);
        run_payout();
    endtask

    task automatic test_reset_mid_change();
        bus.price = 8'd10;
        drive_coin(20);
        do_vend("rst_mid", 8'd20);
        n_cmp++;
        if (bus.change_req !== 1'b1 || bus.credit !== 8'd10) begin
            n_bad++;
            $display("FAIL rst_mid_pre: got req=%b credit=%0d, want 1/10", bus.change_req, bus.credit);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus.dispense, bus.change_req, bus.busy} !== 3'b000 || bus.credit !== '0 || bus.residue !== '0) begin
            n_bad++;
            $display("FAIL rst_mid_outputs: got flags=%b credit=%0d residue=%0d, want 000/0/0",
                     {bus.dispense, bus.change_req, bus.busy}, bus.credit, bus.residue);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick(3);
        n_cmp++;
        if (bus.busy !== 1'b0 || bus.change_req !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_mid_after: got busy=%b req=%b, want 0/0", bus.busy, bus.change_req);
        end
        mdl_credit = 0;
    endtask

    initial begin
        test_reset();
        test_exact_price();
        test_change();
        test_cancel_refund();
        test_coin_with_cancel();
        test_spurious_acks();
        test_timeout();
        test_saturation();
        test_zero_price();
        test_reset_mid_change();
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_leftover: got %0d pending, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
